// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg: shared types for the MAC operand feeder.
//   mac_feeder_state_t : feeder FSM state encoding
//   `MAC_FEEDER_FF     : async active-low reset register (clk / arst_n_in)
`ifndef MAC_FEEDER_FF
`define MAC_FEEDER_FF(q, d, rst) \
   always_ff @(posedge clk or negedge arst_n_in) begin \
      if (!arst_n_in) q <= (rst); \
      else            q <= (d); \
   end
`endif

package mac_feeder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STREAM  = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_OUTPUT  = 3'd4
   } mac_feeder_state_t;

endpackage : mac_feeder_pkg

// File: rtl/mac_feeder.sv
// mac_feeder: sequences one dot product through an external MAC.
//   clk, arst_n_in               : clock, async active-low reset
//   start, len                   : job request and product count (sampled on start)
//   busy                         : high whenever the FSM is not idle
//   op_valid/op_ready/op_a/op_b  : operand stream
//   mac_input_valid, mac_accumulate_internal, mac_a, mac_b : MAC drive
//   mac_out                      : MAC result
//   res_valid/res_ready/res_data : result handshake
module mac_feeder
   import mac_feeder_pkg::*;
#(
   parameter int unsigned A_WIDTH      = 16,
   parameter int unsigned B_WIDTH      = 16,
   parameter int unsigned OUTPUT_WIDTH = 16,
   parameter int unsigned CNT_WIDTH    = 8
) (
   input  logic                           clk,
   input  logic                           arst_n_in,
   input  logic                           start,
   input  logic [CNT_WIDTH-1:0]           len,
   output logic                           busy,
   input  logic                           op_valid,
   output logic                           op_ready,
   input  logic signed [A_WIDTH-1:0]      op_a,
   input  logic signed [B_WIDTH-1:0]      op_b,
   output logic                           mac_input_valid,
   output logic                           mac_accumulate_internal,
   output logic [A_WIDTH-1:0]             mac_a,
   output logic [B_WIDTH-1:0]             mac_b,
   input  logic signed [OUTPUT_WIDTH-1:0] mac_out,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [OUTPUT_WIDTH-1:0]        res_data
);

   mac_feeder_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]        len_q, len_d;
   logic [A_WIDTH-1:0]          mac_a_q, mac_a_d;
   logic [B_WIDTH-1:0]          mac_b_q, mac_b_d;
   logic                        mac_valid_q, mac_valid_d;
   logic                        mac_acc_q, mac_acc_d;
   logic [OUTPUT_WIDTH-1:0]     res_data_q, res_data_d;
   logic                        res_valid_q, res_valid_d;
   logic                        last_c;

   // Final product of the job is the one taken at cnt == len_q-1; cnt never passes it.
   assign last_c = (cnt_q == (len_q - CNT_WIDTH'(1)));

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      mac_a_d     = mac_a_q;
      mac_b_d     = mac_b_q;
      mac_acc_d   = mac_acc_q;
      mac_valid_d = 1'b0;
      res_data_d  = res_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start && (len != '0)) begin
               len_d   = len;
               cnt_d   = '0;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (op_valid) begin
               mac_a_d     = op_a;
               mac_b_d     = op_b;
               mac_valid_d = 1'b1;
               // First product restarts the MAC accumulator.
               mac_acc_d   = (cnt_q != '0);
               if (last_c) state_d = ST_DRAIN;
               else        cnt_d   = cnt_q + CNT_WIDTH'(1);
            end
         end
         // MAC absorbs the last product during this cycle.
         ST_DRAIN:   state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            res_data_d = mac_out;
            state_d    = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default:    state_d = ST_IDLE;
      endcase

      res_valid_d = (state_d == ST_OUTPUT);
   end

   `MAC_FEEDER_FF(state_q,     state_d,     ST_IDLE)
   `MAC_FEEDER_FF(cnt_q,       cnt_d,       '0)
   `MAC_FEEDER_FF(len_q,       len_d,       '0)
   `MAC_FEEDER_FF(mac_a_q,     mac_a_d,     '0)
   `MAC_FEEDER_FF(mac_b_q,     mac_b_d,     '0)
   `MAC_FEEDER_FF(mac_valid_q, mac_valid_d, 1'b0)
   `MAC_FEEDER_FF(mac_acc_q,   mac_acc_d,   1'b0)
   `MAC_FEEDER_FF(res_data_q,  res_data_d,  '0)
   `MAC_FEEDER_FF(res_valid_q, res_valid_d, 1'b0)

   assign busy                    = (state_q != ST_IDLE);
   assign op_ready                = (state_q == ST_STREAM);
   assign mac_input_valid         = mac_valid_q;
   assign mac_accumulate_internal = mac_acc_q;
   assign mac_a                   = mac_a_q;
   assign mac_b                   = mac_b_q;
   assign res_valid               = res_valid_q;
   assign res_data                = res_data_q;

endmodule : mac_feeder

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [7:0]         len;
   logic               busy;
   logic               op_valid;
   logic               op_ready;
   logic signed [15:0] op_a, op_b;
   logic               mac_input_valid, mac_accumulate_internal;
   logic [15:0]        mac_a, mac_b;
   logic signed [15:0] mac_out;
   logic               res_valid, res_ready;
   logic [15:0]        res_data;

   always #5 clk = ~clk;

   mac_feeder dut (
      .clk                     (clk),
      .arst_n_in               (rst_n),
      .start                   (start),
      .len                     (len),
      .busy                    (busy),
      .op_valid                (op_valid),
      .op_ready                (op_ready),
      .op_a                    (op_a),
      .op_b                    (op_b),
      .mac_input_valid         (mac_input_valid),
      .mac_accumulate_internal (mac_accumulate_internal),
      .mac_a                   (mac_a),
      .mac_b                   (mac_b),
      .mac_out                 (mac_out),
      .res_valid               (res_valid),
      .res_ready               (res_ready),
      .res_data                (res_data)
   );

   // Reference MAC with partial_sum_in tied to 0 and no output scaling.
   logic signed [15:0] acc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc <= '0;
      else if (mac_input_valid)
         acc <= (mac_accumulate_internal ? acc : 16'sd0) +
                16'($signed(mac_a) * $signed(mac_b));
   end
   assign mac_out = acc;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard of expected results and operand queues for the driver.
   logic [15:0]        sb_q[$];
   logic signed [15:0] qa[$], qb[$];
   bit                 vpat[$];
   int                 mac_pulses = 0;

   // Monitor: MAC drive follows each transfer by one cycle; results popped on handshake.
   bit                 prev_xfer = 0;
   logic [15:0]        prev_a, prev_b;
   int                 prev_idx, idx = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_xfer = 0;
         idx       = 0;
      end else begin
         check_eq("mac_valid_follows_xfer", mac_input_valid, prev_xfer);
         if (prev_xfer) begin
            check_eq("mac_a", mac_a, prev_a);
            check_eq("mac_b", mac_b, prev_b);
            check_eq("mac_acc_flag", mac_accumulate_internal, prev_idx != 0);
         end
         if (mac_input_valid) mac_pulses++;
         if (res_valid && res_ready) begin
            if (sb_q.size() == 0) check_eq("sb_unexpected_result", 1, 0);
            else                  check_eq("res_data", res_data, sb_q.pop_front());
         end
         if (!busy) idx = 0;
         prev_xfer = op_valid && op_ready;
         prev_a    = op_a;
         prev_b    = op_b;
         prev_idx  = idx;
         if (prev_xfer) idx++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      len   = 8'(n);
      tick();
      start = 1'b0;
   endtask

   // Streams qa/qb honouring the op_valid pattern in vpat (then held high).
   task automatic stream(input int n, output bit ok);
      int  i = 0, step = 0;
      bit  v, rdy;
      while (i < n && step < 2000) begin
         v        = (step < vpat.size()) ? vpat[step] : 1'b1;
         op_valid = v;
         op_a     = qa[i];
         op_b     = qb[i];
         rdy      = op_ready;
         tick();
         step++;
         if (v && rdy) i++;
      end
      op_valid = 1'b0;
      ok = (i == n);
      if (!ok) check_eq("stream_timeout", step, 0);
   endtask

   // Complete job: stream, check latency, optional backpressure, release.
   task automatic run_job(input int n, input int hold);
      int          sum = 0, lat;
      bit          ok;
      logic [15:0] held;
      for (int k = 0; k < n; k++) sum += int'(qa[k]) * int'(qb[k]);
      res_ready = (hold == 0);
      do_start(n);
      check_eq("busy_after_start", busy, 1);
      stream(n, ok);
      if (!ok) return;
      sb_q.push_back(16'(sum));
      check_eq("op_ready_after_last", op_ready, 0);
      lat = 1;
      while (!res_valid && lat < 10) begin
         tick();
         lat++;
      end
      check_eq("res_valid_latency", lat, 3);
      if (hold == 0) begin
         tick();
         check_eq("res_valid_pulse", res_valid, 0);
         check_eq("busy_done", busy, 0);
      end else begin
         held = res_data;
         for (int k = 0; k < hold; k++) begin
            start = 1'b1;
            len   = 8'd7;
            tick();
            check_eq("hold_res_valid", res_valid, 1);
            check_eq("hold_res_data", res_data, held);
            check_eq("hold_busy", busy, 1);
         end
         start     = 1'b0;
         res_ready = 1'b1;
         tick();
         res_ready = 1'b0;
         check_eq("release_res_valid", res_valid, 0);
         check_eq("release_busy", busy, 0);
      end
      vpat.delete();
   endtask

   initial begin
      bit ok;
      int p0;
      rst_n = 1'b0; start = 1'b0; len = '0; op_valid = 1'b0;
      op_a = '0; op_b = '0; res_ready = 1'b0;
      #22;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_res_valid", res_valid, 0);
      check_eq("rst_mac_valid", mac_input_valid, 0);
      check_eq("rst_op_ready", op_ready, 0);
      rst_n = 1'b1;
      tick();

      // len=3 back-to-back: 6+20-6 = 20
      qa = '{16'sd2, 16'sd4, -16'sd1}; qb = '{16'sd3, 16'sd5, 16'sd6};
      run_job(3, 0);

      // len=1: -49, first product never accumulates
      qa = '{-16'sd7}; qb = '{16'sd7};
      run_job(1, 0);

      // len=4 with op_valid gaps
      qa = '{16'sd3, -16'sd2, 16'sd10, 16'sd1}; qb = '{16'sd4, 16'sd9, -16'sd3, 16'sd100};
      vpat = '{1, 0, 0, 1, 1, 0, 1};
      p0 = mac_pulses;
      run_job(4, 0);
      check_eq("gap_mac_pulses", mac_pulses - p0, 4);

      // Backpressure for 5 cycles with start pulses while busy
      qa = '{16'sd11, 16'sd12}; qb = '{-16'sd5, 16'sd2};
      run_job(2, 5);

      // len=0 is ignored
      do_start(0);
      for (int k = 0; k < 3; k++) begin
         check_eq("len0_busy", busy, 0);
         check_eq("len0_op_ready", op_ready, 0);
         tick();
      end

      // Maximum length 255 without counter wrap
      qa.delete(); qb.delete();
      for (int k = 0; k < 255; k++) begin
         qa.push_back(16'sd1);
         qb.push_back(16'(k % 3 - 1));
      end
      run_job(255, 0);

      // Reset after 2nd transfer of a len=5 job
      qa = '{16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9}; qb = '{16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9};
      do_start(5);
      stream(2, ok);
      #1 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_op_ready", op_ready, 0);
      check_eq("mid_rst_mac_valid", mac_input_valid, 0);
      check_eq("mid_rst_mac_acc", mac_accumulate_internal, 0);
      check_eq("mid_rst_mac_a", mac_a, 0);
      check_eq("mid_rst_mac_b", mac_b, 0);
      check_eq("mid_rst_res_valid", res_valid, 0);
      check_eq("mid_rst_res_data", res_data, 0);
      tick();
      rst_n = 1'b1;
      tick();
      qa = '{16'sd1, 16'sd1}; qb = '{16'sd1, 16'sd1};
      run_job(2, 0);

      tick();
      check_eq("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mac_feeder
